// File: rtl/pu_mem_rmw_sched.sv
// Round-robin read/write scheduler for PU requesters sharing a 1R1W table RAM.
// Atomic RMWs are tracked in a short address scoreboard that also owns the write-back slot.

module pu_mem_rmw_lane #(
    parameter int ADDR_NBITS = 8,
    parameter int RMW_LAT    = 2
) (
    input  logic                                 rst,
    input  logic                                 req,
    input  logic                                 wr,
    input  logic                                 atomic,
    input  logic                                 ack_pend,
    input  logic [ADDR_NBITS-1:0]                addr,
    input  logic [RMW_LAT:1]                     sb_vld,
    input  logic [RMW_LAT:1][ADDR_NBITS-1:0]     sb_addr,
    input  logic                                 atom_vld,
    input  logic [ADDR_NBITS-1:0]                atom_addr,
    output logic                                 rd_elig,
    output logic                                 wr_elig
);
    logic hit;
    logic base;

    always_comb begin
        hit = 1'b0;
        for (int s = 1; s <= RMW_LAT; s++)
            if (sb_vld[s] && sb_addr[s] == addr) hit = 1'b1;
    end

    assign base    = req & ~ack_pend & ~hit & ~rst;
    assign rd_elig = base & (atomic | ~wr);
    // a plain write must not overtake an atomic to the same word launched this cycle
    assign wr_elig = base & ~atomic & wr & ~(atom_vld && atom_addr == addr);
endmodule

module pu_mem_rmw_sched #(
    parameter int NUM_OF_PU  = 4,
    parameter int ADDR_NBITS = 8,
    parameter int RMW_LAT    = 2,
    localparam int PU_ID_NBITS = (NUM_OF_PU > 1) ? $clog2(NUM_OF_PU) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_OF_PU-1:0]            req,
    input  logic [NUM_OF_PU-1:0]            req_wr,
    input  logic [NUM_OF_PU-1:0]            req_atomic,
    input  logic [NUM_OF_PU*ADDR_NBITS-1:0] req_addr,
    output logic                            rd_en,
    output logic [ADDR_NBITS-1:0]           rd_addr,
    output logic [PU_ID_NBITS-1:0]          rd_sel,
    output logic                            rd_atomic,
    output logic                            wr_en,
    output logic [PU_ID_NBITS-1:0]          wr_sel,
    output logic [ADDR_NBITS-1:0]           wr_addr,
    output logic                            wb_en,
    output logic [ADDR_NBITS-1:0]           wb_addr,
    output logic [PU_ID_NBITS-1:0]          wb_sel,
    output logic [NUM_OF_PU-1:0]            ack
);
    logic [NUM_OF_PU-1:0][ADDR_NBITS-1:0]   addr_v;
    logic [NUM_OF_PU-1:0]                   rd_elig, wr_elig, gnt_oh;
    logic [PU_ID_NBITS-1:0]                 rd_ptr, wr_ptr;
    logic [PU_ID_NBITS:0]                   rd_pick, wr_pick;
    logic [RMW_LAT:1]                       vld_pipe;
    logic [RMW_LAT:1][ADDR_NBITS-1:0]       sb_addr;
    logic [RMW_LAT:1][PU_ID_NBITS-1:0]      sb_sel;
    logic                                   atom_vld;

    assign addr_v = req_addr;

    // Returns {found, index}: first eligible requester at or after ptr, wrapping.
    function automatic logic [PU_ID_NBITS:0] rr_pick(input logic [NUM_OF_PU-1:0] elig,
                                                     input logic [PU_ID_NBITS-1:0] ptr);
        logic [PU_ID_NBITS:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < NUM_OF_PU; k++) begin
            idx = (int'(ptr) + k) % NUM_OF_PU;
            if (!r[PU_ID_NBITS] && elig[idx]) r = {1'b1, PU_ID_NBITS'(idx)};
        end
        return r;
    endfunction

    for (genvar i = 0; i < NUM_OF_PU; i++) begin : g_lane
        pu_mem_rmw_lane #(.ADDR_NBITS(ADDR_NBITS), .RMW_LAT(RMW_LAT)) u_lane (
            .rst       (rst),
            .req       (req[i]),
            .wr        (req_wr[i]),
            .atomic    (req_atomic[i]),
            .ack_pend  (ack[i]),
            .addr      (addr_v[i]),
            .sb_vld    (vld_pipe),
            .sb_addr   (sb_addr),
            .atom_vld  (atom_vld),
            .atom_addr (rd_addr),
            .rd_elig   (rd_elig[i]),
            .wr_elig   (wr_elig[i])
        );
    end

    assign rd_pick   = rr_pick(rd_elig, rd_ptr);
    assign rd_en     = rd_pick[PU_ID_NBITS];
    assign rd_sel    = rd_pick[PU_ID_NBITS-1:0];
    assign rd_addr   = rd_en ? addr_v[rd_sel] : '0;
    assign rd_atomic = rd_en & req_atomic[rd_sel];
    assign atom_vld  = rd_atomic;

    assign wb_en   = vld_pipe[RMW_LAT];
    assign wb_addr = wb_en ? sb_addr[RMW_LAT] : '0;
    assign wb_sel  = wb_en ? sb_sel[RMW_LAT] : '0;

    // the write-back owns the write port in its cycle
    assign wr_pick = rr_pick(wb_en ? '0 : wr_elig, wr_ptr);
    assign wr_en   = wr_pick[PU_ID_NBITS];
    assign wr_sel  = wr_pick[PU_ID_NBITS-1:0];
    assign wr_addr = wr_en ? addr_v[wr_sel] : '0;

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NUM_OF_PU; i++)
            gnt_oh[i] = (rd_en && rd_sel == PU_ID_NBITS'(i)) ||
                        (wr_en && wr_sel == PU_ID_NBITS'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            ack      <= '0;
            vld_pipe <= '0;
            sb_addr  <= '0;
            sb_sel   <= '0;
        end else begin
            if (rd_en) rd_ptr <= (int'(rd_sel) == NUM_OF_PU-1) ? '0 : rd_sel + 1'b1;
            if (wr_en) wr_ptr <= (int'(wr_sel) == NUM_OF_PU-1) ? '0 : wr_sel + 1'b1;
            ack         <= gnt_oh;
            vld_pipe[1] <= atom_vld;
            sb_addr[1]  <= rd_addr;
            sb_sel[1]   <= rd_sel;
            for (int s = 2; s <= RMW_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                sb_addr[s]  <= sb_addr[s-1];
                sb_sel[s]   <= sb_sel[s-1];
            end
        end
    end
endmodule

// File: tb/tb_pu_mem_rmw_sched.sv
// Scoreboard bench for pu_mem_rmw_sched: tests queue expected grants/write-backs/acks
// by cycle, a negedge monitor pops and compares whatever the DUT issues.
module tb_pu_mem_rmw_sched;
    localparam int N = 4, AW = 8, LAT = 2, PW = 2;

    logic            clk = 1'b0, rst = 1'b1;
    logic [N-1:0]    req = '0, req_wr = '0, req_atomic = '0, hold = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic            rd_en, rd_atomic, wr_en, wb_en;
    logic [AW-1:0]   rd_addr, wr_addr, wb_addr;
    logic [PW-1:0]   rd_sel, wr_sel, wb_sel;
    logic [N-1:0]    ack;

    typedef struct { int cyc; int sel; int addr; bit atomic; } ev_t;
    typedef struct { int cyc; logic [N-1:0] mask; } ack_t;
    ev_t  q_rd[$], q_wr[$], q_wb[$];
    ack_t q_ack[$];
    int cyc = 0, n_tests = 0, n_fail = 0;

    pu_mem_rmw_sched #(.NUM_OF_PU(N), .ADDR_NBITS(AW), .RMW_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_atomic(req_atomic),
        .req_addr(req_addr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel),
        .rd_atomic(rd_atomic), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_sel(wb_sel), .ack(ack)
    );

    always #5 clk = ~clk;

    // PU model: drops its request on ack unless told to keep requesting
    always @(posedge clk) begin
        cyc++;
        #1;
        for (int i = 0; i < N; i++)
            if (ack[i] && !hold[i]) req[i] = 1'b0;
    end

    function automatic void add_ack(int c, int p);
        ack_t a;
        int pos = q_ack.size();
        for (int i = 0; i < q_ack.size(); i++) begin
            if (q_ack[i].cyc == c) begin q_ack[i].mask[p] = 1'b1; return; end
            if (q_ack[i].cyc > c && pos == q_ack.size()) pos = i;
        end
        a.cyc = c; a.mask = '0; a.mask[p] = 1'b1;
        q_ack.insert(pos, a);
    endfunction

    function automatic ev_t mk(int c, int sel, int addr, bit at);
        ev_t e;
        e.cyc = c; e.sel = sel; e.addr = addr; e.atomic = at;
        return e;
    endfunction

    function automatic void exp_rd(int c, int sel, int addr, bit at, bit with_ack);
        q_rd.push_back(mk(c, sel, addr, at));
        if (with_ack) add_ack(c + 1, sel);
    endfunction

    function automatic void exp_wr(int c, int sel, int addr);
        q_wr.push_back(mk(c, sel, addr, 1'b0));
        add_ack(c + 1, sel);
    endfunction

    function automatic void exp_wb(int c, int sel, int addr);
        q_wb.push_back(mk(c, sel, addr, 1'b1));
    endfunction

    function automatic int pending();
        return q_rd.size() + q_wr.size() + q_wb.size() + q_ack.size();
    endfunction

    always @(negedge clk) begin : mon
        ev_t  e;
        ack_t a;
        if (rd_en) begin
            n_tests++;
            if (q_rd.size() == 0) begin
                n_fail++;
                $display("FAIL rd_grant: unexpected at cyc %0d sel %0d addr %0h", cyc, rd_sel, rd_addr);
            end else begin
                e = q_rd.pop_front();
                if (e.cyc !== cyc || e.sel !== int'(rd_sel) || e.addr !== int'(rd_addr) || e.atomic !== rd_atomic) begin
                    n_fail++;
                    $display("FAIL rd_grant: got cyc %0d sel %0d addr %0h at %0b, want cyc %0d sel %0d addr %0h at %0b",
                             cyc, rd_sel, rd_addr, rd_atomic, e.cyc, e.sel, e.addr, e.atomic);
                end
            end
        end else if (q_rd.size() > 0 && q_rd[0].cyc <= cyc) begin
            n_tests++; n_fail++;
            e = q_rd.pop_front();
            $display("FAIL rd_grant: none at cyc %0d, want sel %0d addr %0h", cyc, e.sel, e.addr);
        end

        if (wr_en) begin
            n_tests++;
            if (q_wr.size() == 0) begin
                n_fail++;
                $display("FAIL wr_grant: unexpected at cyc %0d sel %0d addr %0h", cyc, wr_sel, wr_addr);
            end else begin
                e = q_wr.pop_front();
                if (e.cyc !== cyc || e.sel !== int'(wr_sel) || e.addr !== int'(wr_addr)) begin
                    n_fail++;
                    $display("FAIL wr_grant: got cyc %0d sel %0d addr %0h, want cyc %0d sel %0d addr %0h",
                             cyc, wr_sel, wr_addr, e.cyc, e.sel, e.addr);
                end
            end
        end else if (q_wr.size() > 0 && q_wr[0].cyc <= cyc) begin
            n_tests++; n_fail++;
            e = q_wr.pop_front();
            $display("FAIL wr_grant: none at cyc %0d, want sel %0d addr %0h", cyc, e.sel, e.addr);
        end

        if (wb_en) begin
            n_tests++;
            if (q_wb.size() == 0) begin
                n_fail++;
                $display("FAIL write_back: unexpected at cyc %0d sel %0d addr %0h", cyc, wb_sel, wb_addr);
            end else begin
                e = q_wb.pop_front();
                if (e.cyc !== cyc || e.sel !== int'(wb_sel) || e.addr !== int'(wb_addr) || wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write_back: got cyc %0d sel %0d addr %0h wr_en %0b, want cyc %0d sel %0d addr %0h wr_en 0",
                             cyc, wb_sel, wb_addr, wr_en, e.cyc, e.sel, e.addr);
                end
            end
        end else if (q_wb.size() > 0 && q_wb[0].cyc <= cyc) begin
            n_tests++; n_fail++;
            e = q_wb.pop_front();
            $display("FAIL write_back: none at cyc %0d, want sel %0d addr %0h", cyc, e.sel, e.addr);
        end

        if (ack !== '0) begin
            n_tests++;
            if (q_ack.size() == 0 || q_ack[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL ack: unexpected %b at cyc %0d, want 0000", ack, cyc);
            end else begin
                a = q_ack.pop_front();
                if (a.mask !== ack) begin
                    n_fail++;
                    $display("FAIL ack: got %b at cyc %0d, want %b", ack, cyc, a.mask);
                end
            end
        end else if (q_ack.size() > 0 && q_ack[0].cyc <= cyc) begin
            n_tests++; n_fail++;
            a = q_ack.pop_front();
            $display("FAIL ack: got 0000 at cyc %0d, want %b", cyc, a.mask);
        end
    end

    task automatic set_req(int i, bit wr, bit at, int addr);
        req_wr[i] = wr;
        req_atomic[i] = at;
        req_addr[i*AW +: AW] = AW'(addr);
        req[i] = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        req = '0; hold = '0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic drain(string name);
        repeat (6) @(posedge clk);
        #2;
        n_tests++;
        if (pending() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events never seen, want 0", name, pending());
        end
    endtask

    task automatic check_zero(string name);
        n_tests++;
        if ({rd_en, rd_addr, rd_sel, rd_atomic, wr_en, wr_sel, wr_addr, wb_en, wb_addr, wb_sel, ack} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs rd %0b/%0h/%0d wr %0b/%0h/%0d wb %0b/%0h/%0d ack %b, want all 0",
                     name, rd_en, rd_addr, rd_sel, wr_en, wr_addr, wr_sel, wb_en, wb_addr, wb_sel, ack);
        end
    endtask

    task automatic test_reset();
        hold = '1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, i);
        @(negedge clk);
        check_zero("reset_with_req");
        @(posedge clk); #2;
        req = '0; hold = '0; rst = 1'b0;
        @(negedge clk);
        check_zero("reset_release_idle");
    endtask

    task automatic test_rr_reads();
        int c0;
        do_reset();
        @(posedge clk); #2;
        c0 = cyc; hold = '1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 8'h80 + i);
        for (int k = 0; k < 5; k++) exp_rd(c0 + k, k % N, 8'h80 + (k % N), 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #2 req = '0; hold = '0;
        drain("rr_reads");
    endtask

    task automatic test_atomic_blocks_read();
        int c0;
        do_reset();
        @(posedge clk); #2;
        c0 = cyc;
        set_req(1, 1'b0, 1'b1, 8'h10);
        exp_rd(c0, 1, 8'h10, 1'b1, 1'b1);
        exp_wb(c0 + 2, 1, 8'h10);
        exp_rd(c0 + 3, 2, 8'h10, 1'b0, 1'b1);
        @(posedge clk); #2;
        set_req(2, 1'b0, 1'b0, 8'h10);
        drain("atomic_blocks_read");
    endtask

    task automatic test_atomic_blocks_write();
        int c0;
        do_reset();
        @(posedge clk); #2;
        c0 = cyc;
        set_req(0, 1'b0, 1'b1, 8'h20);
        set_req(3, 1'b1, 1'b0, 8'h20);
        exp_rd(c0, 0, 8'h20, 1'b1, 1'b1);
        exp_wb(c0 + 2, 0, 8'h20);
        exp_wr(c0 + 3, 3, 8'h20);
        drain("atomic_blocks_write");
    endtask

    task automatic test_wb_priority();
        int c0;
        do_reset();
        @(posedge clk); #2;
        c0 = cyc;
        set_req(0, 1'b0, 1'b1, 8'h30);
        exp_rd(c0, 0, 8'h30, 1'b1, 1'b1);
        exp_wb(c0 + 2, 0, 8'h30);
        exp_wr(c0 + 3, 1, 8'h40);
        exp_wr(c0 + 4, 2, 8'h50);
        repeat (2) @(posedge clk);
        #2;
        set_req(1, 1'b1, 1'b0, 8'h40);
        set_req(2, 1'b1, 1'b0, 8'h50);
        drain("wb_priority");
    endtask

    task automatic test_back_to_back();
        int c0;
        do_reset();
        @(posedge clk); #2;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b0, 1'b1, i + 1);
            exp_rd(c0 + i, i, i + 1, 1'b1, 1'b1);
            exp_wb(c0 + 2 + i, i, i + 1);
        end
        exp_wr(c0 + 1, 3, 8'h07);
        @(posedge clk); #2;
        set_req(3, 1'b1, 1'b0, 8'h07);
        drain("back_to_back");
    endtask

    task automatic test_same_addr_rw();
        int c0;
        do_reset();
        @(posedge clk); #2;
        c0 = cyc;
        set_req(0, 1'b0, 1'b0, 8'h60);
        set_req(1, 1'b1, 1'b0, 8'h60);
        exp_rd(c0, 0, 8'h60, 1'b0, 1'b1);
        exp_wr(c0, 1, 8'h60);
        drain("same_addr_rw");
    endtask

    task automatic test_reset_midflight();
        int c1;
        do_reset();
        @(posedge clk); #2;
        hold[1] = 1'b1;
        set_req(1, 1'b0, 1'b1, 8'h44);
        exp_rd(cyc, 1, 8'h44, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_zero("midflight_reset_a");
        @(negedge clk);
        check_zero("midflight_reset_b");
        @(posedge clk); #2;
        req = '0; hold = '0; rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        c1 = cyc;
        set_req(0, 1'b0, 1'b0, 8'h01);
        set_req(3, 1'b0, 1'b0, 8'h02);
        exp_rd(c1, 0, 8'h01, 1'b0, 1'b1);
        exp_rd(c1 + 1, 3, 8'h02, 1'b0, 1'b1);
        drain("reset_midflight");
    endtask

    initial begin
        test_reset();
        test_rr_reads();
        test_atomic_blocks_read();
        test_atomic_blocks_write();
        test_wb_priority();
        test_back_to_back();
        test_same_addr_rw();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
